fetch_pc_reg: RTL and testbench
===============================

// Module: fetch_pc_reg
// PURPOSE
//   Parametrised fetch-stage PC/status register for the Y86-64 pipeline.
//   Holds the predicted PC, fetch status and valid bit. Selects the next fetch PC
//   from three sources: misprediction recovery (M), return (W) and prediction.
//   Adds stall, bubble and redirect-under-stall handling, a sticky halt state
//   and a stall-cycle counter. Sits between the hazard unit and the fetch logic.
// PARAMETERS
//   ADDR_W    64  width of every PC/address port
//   STAT_W    4   width of status codes
//   STAT_AOK  1   status code meaning "normal operation"
//   RESET_PC  0   F_predPC value after reset (ADDR_W bits)
//   CNT_W     16  width of stall_cnt
// PORTS
//   clk           in   1       clock, all state updates on posedge
//   rst_n         in   1       asynchronous active-low reset
//   F_stall       in   1       hazard unit: hold F register
//   F_bubble      in   1       hazard unit: insert bubble into F
//   predPC        in   ADDR_W  predicted next PC from fetch logic
//   F_stat_in     in   STAT_W  status produced by fetch this cycle
//   M_mispredict  in   1       M stage: taken-predicted jump was not taken
//   M_valA        in   ADDR_W  fall-through PC carried by M stage
//   W_ret         in   1       W stage: ret instruction completing
//   W_valM        in   ADDR_W  return address read by ret
//   f_pc          out  ADDR_W  selected fetch PC (combinational)
//   F_predPC      out  ADDR_W  registered predicted PC
//   f_stat        out  STAT_W  registered fetch status
//   F_valid       out  1       F holds a real (non-bubble) entry
//   halted        out  1       sticky halt: non-AOK status was captured
//   stall_cnt     out  CNT_W   saturating count of stalled cycles
// BEHAVIOUR
//   Reset (rst_n=0, async): F_predPC=RESET_PC, f_stat=STAT_AOK, F_valid=0,
//     halted=0, stall_cnt=0, FSM=RUN. Reset may land mid-stall or in HALT; all
//     state clears immediately.
//   f_pc select (combinational, priority order):
//     M_mispredict ? M_valA : W_ret ? W_valM : F_predPC.
//     Both M_mispredict and W_ret high: M_valA wins.
//   redirect = M_mispredict | W_ret.
//   FSM states: RUN, HALT. HALT is left only by reset.
//   Per posedge in RUN, first matching row applies:
//     1 F_stall & redirect: F_predPC<=f_pc. f_stat and F_valid are held.
//       A redirect target is never lost under a stall.
//     2 F_stall: F_predPC, f_stat and F_valid are held.
//     3 F_bubble: F_predPC<=f_pc, f_stat<=STAT_AOK, F_valid<=0.
//     4 normal: F_predPC<=predPC, f_stat<=F_stat_in, F_valid<=1.
//       If F_stat_in!=STAT_AOK, go to HALT and set halted<=1 in the same edge.
//   F_stall and F_bubble both high: stall wins (rows 1/2). This is not an error.
//   HALT: F_predPC, f_stat, F_valid and stall_cnt are frozen. Inputs are ignored.
//     halted=1. f_pc stays combinational.
//   stall_cnt: +1 on each RUN posedge with F_stall=1. Saturates at 2^CNT_W-1
//     and does not wrap.
//   Latency: one cycle from input to registered outputs. No internal buffering.
// TESTING
//   T1 reset: rst_n low mid-cycle -> outputs = 0 / STAT_AOK / 0 / 0 / 0
//      immediately, with no clock edge needed.
//   T2 normal + stall: predPC=0x0A, F_stat_in=1 -> F_predPC=0x0A, F_valid=1.
//      Then F_stall for 3 cycles with predPC=0x14 -> F_predPC stays 0x0A,
//      stall_cnt=3.
//   T3 select priority: F_predPC=0x0A, M_mispredict=1 with M_valA=0x20,
//      W_ret=1 with W_valM=0x30 -> f_pc=0x20.
//      Drop M_mispredict -> f_pc=0x30.
//   T4 redirect under stall: F_stall=1, W_ret=1, W_valM=0x40 -> next
//      F_predPC=0x40. f_stat and F_valid unchanged.
//   T5 bubble, and stall+bubble: F_bubble=1 -> F_valid=0, f_stat=1.
//      F_stall=F_bubble=1 -> all registers held.
//   T6 halt + saturation: F_stat_in=2 (HLT) captured -> halted=1. Later predPC
//      and F_stat_in changes are ignored until rst_n. With CNT_W=2, 5 stalls
//      -> stall_cnt=3.

Source files
------------

// File: rtl/fetch_pc_reg.sv
// Fetch-stage PC/status register for the Y86-64 pipeline: next-PC select,
// stall/bubble/redirect handling, sticky halt and a saturating stall counter.
module fetch_pc_reg #(
    parameter int unsigned              ADDR_W   = 64,
    parameter int unsigned              STAT_W   = 4,
    parameter logic [STAT_W-1:0]        STAT_AOK = 1,
    parameter logic [ADDR_W-1:0]        RESET_PC = '0,
    parameter int unsigned              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              F_stall,
    input  logic              F_bubble,
    input  logic [ADDR_W-1:0] predPC,
    input  logic [STAT_W-1:0] F_stat_in,
    input  logic              M_mispredict,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic              W_ret,
    input  logic [ADDR_W-1:0] W_valM,
    output logic [ADDR_W-1:0] f_pc,
    output logic [ADDR_W-1:0] F_predPC,
    output logic [STAT_W-1:0] f_stat,
    output logic              F_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_pred_pc, w_pred_pc_d;
    logic [STAT_W-1:0]   r_stat, w_stat_d;
    logic                r_valid, w_valid_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic                w_redirect;

    // Misprediction recovery outranks a completing ret.
    assign f_pc       = M_mispredict ? M_valA : (W_ret ? W_valM : r_pred_pc);
    assign w_redirect = M_mispredict | W_ret;

    always_comb begin
        w_state_d   = r_state;
        w_pred_pc_d = r_pred_pc;
        w_stat_d    = r_stat;
        w_valid_d   = r_valid;
        w_cnt_d     = r_cnt;
        unique case (r_state)
            StRun: begin
                if (F_stall) begin
                    if (r_cnt != {CNT_W{1'b1}}) begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                    // A redirect must land even while F is held.
                    if (w_redirect) begin
                        w_pred_pc_d = f_pc;
                    end
                end else if (F_bubble) begin
                    w_pred_pc_d = f_pc;
                    w_stat_d    = STAT_AOK;
                    w_valid_d   = 1'b0;
                end else begin
                    w_pred_pc_d = predPC;
                    w_stat_d    = F_stat_in;
                    w_valid_d   = 1'b1;
                    if (F_stat_in != STAT_AOK) begin
                        w_state_d = StHalt;
                    end
                end
            end
            StHalt: begin
                w_state_d = StHalt;
            end
            default: begin
                w_state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StRun;
            r_pred_pc <= RESET_PC;
            r_stat    <= STAT_AOK;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_d;
            r_pred_pc <= w_pred_pc_d;
            r_stat    <= w_stat_d;
            r_valid   <= w_valid_d;
            r_cnt     <= w_cnt_d;
        end
    end

    assign F_predPC  = r_pred_pc;
    assign f_stat    = r_stat;
    assign F_valid   = r_valid;
    assign halted    = (r_state == StHalt);
    assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_pc_reg.sv
// Self-checking bench for fetch_pc_reg: directed vector table, halt/saturation
// sequences and randomized traffic against a behavioural model.
module tb_fetch_pc_reg;

    logic        clk;
    logic        rst_n;
    logic        F_stall, F_bubble, M_mispredict, W_ret;
    logic [63:0] predPC, M_valA, W_valM;
    logic [3:0]  F_stat_in;
    logic [63:0] f_pc, F_predPC;
    logic [3:0]  f_stat;
    logic        F_valid, halted;
    logic [15:0] stall_cnt;
    logic [63:0] f_pc_s, F_predPC_s;
    logic [3:0]  f_stat_s;
    logic        F_valid_s, halted_s;
    logic [1:0]  stall_cnt_s;

    fetch_pc_reg dut (
        .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .F_bubble(F_bubble),
        .predPC(predPC), .F_stat_in(F_stat_in), .M_mispredict(M_mispredict),
        .M_valA(M_valA), .W_ret(W_ret), .W_valM(W_valM), .f_pc(f_pc),
        .F_predPC(F_predPC), .f_stat(f_stat), .F_valid(F_valid), .halted(halted),
        .stall_cnt(stall_cnt)
    );

    fetch_pc_reg #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .F_bubble(F_bubble),
        .predPC(predPC), .F_stat_in(F_stat_in), .M_mispredict(M_mispredict),
        .M_valA(M_valA), .W_ret(W_ret), .W_valM(W_valM), .f_pc(f_pc_s),
        .F_predPC(F_predPC_s), .f_stat(f_stat_s), .F_valid(F_valid_s),
        .halted(halted_s), .stall_cnt(stall_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: architectural state plus an unbounded stall count.
    logic [63:0] m_pc;
    logic [3:0]  m_stat;
    logic        m_valid;
    logic        m_halt;
    longint      m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_fpc();
        return M_mispredict ? M_valA : (W_ret ? W_valM : m_pc);
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step();
        if (!m_halt) begin
            if (F_stall) begin
                m_cnt++;
                if (M_mispredict || W_ret) m_pc = m_fpc();
            end else if (F_bubble) begin
                m_pc    = m_fpc();
                m_stat  = 4'd1;
                m_valid = 1'b0;
            end else begin
                m_pc    = predPC;
                m_stat  = F_stat_in;
                m_valid = 1'b1;
                if (F_stat_in != 4'd1) m_halt = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".f_pc"}, f_pc, m_fpc());
        chk({tag, ".F_predPC"}, F_predPC, m_pc);
        chk({tag, ".f_stat"}, {60'd0, f_stat}, {60'd0, m_stat});
        chk({tag, ".F_valid"}, {63'd0, F_valid}, {63'd0, m_valid});
        chk({tag, ".halted"}, {63'd0, halted}, {63'd0, m_halt});
        chk({tag, ".stall_cnt"}, {48'd0, stall_cnt}, 64'(sat(m_cnt, 65535)));
        chk({tag, ".stall_cnt_sat"}, {62'd0, stall_cnt_s}, 64'(sat(m_cnt, 3)));
    endtask

    task automatic set_in(input logic st, input logic bu, input logic mi, input logic rt,
                          input logic [63:0] pp, input logic [3:0] si,
                          input logic [63:0] va, input logic [63:0] vm);
        F_stall = st; F_bubble = bu; M_mispredict = mi; W_ret = rt;
        predPC = pp; F_stat_in = si; M_valA = va; W_valM = vm;
    endtask

    // Reset lands mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, ".rst_pc"}, F_predPC, 64'h0);
        chk({tag, ".rst_stat"}, {60'd0, f_stat}, 64'd1);
        chk({tag, ".rst_valid"}, {63'd0, F_valid}, 64'd0);
        chk({tag, ".rst_halted"}, {63'd0, halted}, 64'd0);
        chk({tag, ".rst_cnt"}, {48'd0, stall_cnt}, 64'd0);
        chk({tag, ".rst_cnt_sat"}, {62'd0, stall_cnt_s}, 64'd0);
        m_pc = '0; m_stat = 4'd1; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        st, bu, mi, rt;
        logic [63:0] pp;
        logic [3:0]  si;
        logic [63:0] va, vm;
        logic [63:0] e_fpc, e_pc;
        logic [3:0]  e_stat;
        logic        e_valid;
        int          e_cnt;
    } vec_t;

    vec_t vecs[13];

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 64'h0, 4'd1, 64'h0, 64'h0);
        m_pc = '0; m_stat = 4'd1; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 0;
        #12;
        check_model("init");
        @(negedge clk);
        rst_n = 1'b1;

        //           st bu mi rt pred     si va      vm       f_pc     F_predPC st v cnt
        vecs[0]  = '{0, 0, 0, 0, 64'h0A, 1, 64'h00, 64'h00, 64'h00, 64'h0A, 1, 1, 0};
        vecs[1]  = '{1, 0, 0, 0, 64'h14, 1, 64'h00, 64'h00, 64'h0A, 64'h0A, 1, 1, 1};
        vecs[2]  = '{1, 0, 0, 0, 64'h14, 1, 64'h00, 64'h00, 64'h0A, 64'h0A, 1, 1, 2};
        vecs[3]  = '{1, 0, 0, 0, 64'h14, 1, 64'h00, 64'h00, 64'h0A, 64'h0A, 1, 1, 3};
        vecs[4]  = '{1, 0, 1, 1, 64'h14, 1, 64'h20, 64'h30, 64'h20, 64'h20, 1, 1, 4};
        vecs[5]  = '{1, 0, 0, 1, 64'h14, 1, 64'h20, 64'h30, 64'h30, 64'h30, 1, 1, 5};
        vecs[6]  = '{1, 0, 0, 1, 64'h14, 1, 64'h20, 64'h40, 64'h40, 64'h40, 1, 1, 6};
        vecs[7]  = '{0, 1, 0, 0, 64'h14, 1, 64'h00, 64'h00, 64'h40, 64'h40, 1, 0, 6};
        vecs[8]  = '{0, 0, 0, 0, 64'h50, 1, 64'h00, 64'h00, 64'h40, 64'h50, 1, 1, 6};
        vecs[9]  = '{1, 1, 0, 0, 64'h60, 1, 64'h00, 64'h00, 64'h50, 64'h50, 1, 1, 7};
        vecs[10] = '{0, 1, 1, 0, 64'h60, 1, 64'h70, 64'h00, 64'h70, 64'h70, 1, 0, 7};
        vecs[11] = '{1, 1, 1, 0, 64'h60, 1, 64'h80, 64'h00, 64'h80, 64'h80, 1, 0, 8};
        vecs[12] = '{0, 0, 0, 1, 64'h90, 1, 64'h00, 64'h99, 64'h99, 64'h90, 1, 1, 8};

        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].st, vecs[i].bu, vecs[i].mi, vecs[i].rt, vecs[i].pp,
                   vecs[i].si, vecs[i].va, vecs[i].vm);
            #1;
            chk($sformatf("vec%0d.f_pc", i), f_pc, vecs[i].e_fpc);
            tick();
            chk($sformatf("vec%0d.F_predPC", i), F_predPC, vecs[i].e_pc);
            chk($sformatf("vec%0d.f_stat", i), {60'd0, f_stat}, {60'd0, vecs[i].e_stat});
            chk($sformatf("vec%0d.F_valid", i), {63'd0, F_valid}, {63'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d.halted", i), {63'd0, halted}, 64'd0);
            chk($sformatf("vec%0d.stall_cnt", i), {48'd0, stall_cnt}, 64'(vecs[i].e_cnt));
        end

        // Halt capture, then everything frozen while inputs keep changing.
        set_in(0, 0, 0, 0, 64'hA0, 4'd2, 64'h0, 64'h0);
        tick();
        chk("halt.halted", {63'd0, halted}, 64'd1);
        chk("halt.pc", F_predPC, 64'hA0);
        chk("halt.stat", {60'd0, f_stat}, 64'd2);
        for (int i = 0; i < 4; i++) begin
            set_in(i[0], i[1], i[1], i[0], 64'hB0 + 64'(i), 4'd1, 64'hC0, 64'hD0);
            tick();
            chk("frozen.pc", F_predPC, 64'hA0);
            chk("frozen.cnt", {48'd0, stall_cnt}, 64'd8);
            check_model("frozen");
        end
        do_reset("rst_halt");

        // Saturation of the 2-bit counter; reset then lands mid-stall.
        set_in(1, 0, 0, 0, 64'h14, 4'd1, 64'h0, 64'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("sat.cnt_sat", {62'd0, stall_cnt_s}, 64'd3);
        chk("sat.cnt", {48'd0, stall_cnt}, 64'd5);
        chk("sat.pc", F_predPC, 64'h0);
        do_reset("rst_stall");

        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                   $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
                   {$urandom, $urandom}, ($urandom_range(0, 39) == 0) ? 4'($urandom_range(2, 4)) : 4'd1,
                   {$urandom, $urandom}, {$urandom, $urandom});
            tick();
            check_model("rand");
            if (m_halt && $urandom_range(0, 7) == 0) do_reset("rand_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
